// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_unit                                                    |
// | Purpose  : Instruction fetch stage. Reads two 16-bit program-memory      |
// |            words (low, then high) per PC and assembles a 32-bit          |
// |            instruction. A one-entry tagged buffer supplies repeat        |
// |            accesses to an unchanged PC without bus traffic.              |
// | Ports    : clk, rst (sync, active-high)                                  |
// |            pc_addr[15:0]  in  CPU program address                        |
// |            instr[31:0]    out {high word, low word}                      |
// |            instr_valid    out instr belongs to pc_addr                   |
// |            cpu_stall      out ~instr_valid                               |
// |            mem_addr[15:0] out word address (registered)                  |
// |            mem_rd         out read request (registered)                  |
// |            mem_data[15:0] in  read data, valid with mem_ack              |
// |            mem_ack        in  read completion                            |
// | Options  : FETCH_PREFETCH_EN adds a one-entry next-PC prefetch buffer.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module fetch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_addr,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        cpu_stall,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [15:0] mem_data,
    input  logic        mem_ack
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RD_LO = 2'd1;
    localparam logic [1:0] S_RD_HI = 2'd2;

    logic [1:0]  r_state;
    logic [15:0] r_fetch_tag;
    logic [15:0] r_lo;
    logic        r_buf_valid;
    logic [15:0] r_buf_tag;
    logic [31:0] r_buf_data;
    logic        r_mem_rd;
    logic [15:0] r_mem_addr;
    logic        w_main_hit;

    assign w_main_hit = r_buf_valid && (r_buf_tag == pc_addr);

`ifdef FETCH_PREFETCH_EN
    logic        r_pf_valid;
    logic [15:0] r_pf_tag;
    logic [31:0] r_pf_data;
    logic        r_is_pf;      // current bus pair targets the prefetch entry
    logic [15:0] w_pc_next;
    logic        w_pf_hit;
    logic        w_pf_have_next;

    assign w_pc_next      = pc_addr + 16'd1;   // wraps 0xFFFF -> 0x0000
    assign w_pf_hit       = r_pf_valid && (r_pf_tag == pc_addr);
    assign w_pf_have_next = r_pf_valid && (r_pf_tag == w_pc_next);
    assign instr_valid    = w_main_hit | w_pf_hit;
    assign instr          = (w_pf_hit && !w_main_hit) ? r_pf_data : r_buf_data;
`else
    assign instr_valid    = w_main_hit;
    assign instr          = r_buf_data;
`endif

    assign cpu_stall = ~instr_valid;
    assign mem_rd    = r_mem_rd;
    assign mem_addr  = r_mem_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_fetch_tag <= 16'd0;
            r_lo        <= 16'd0;
            r_buf_valid <= 1'b0;
            r_buf_tag   <= 16'd0;
            r_buf_data  <= 32'd0;
            r_mem_rd    <= 1'b0;
            r_mem_addr  <= 16'd0;
`ifdef FETCH_PREFETCH_EN
            r_pf_valid  <= 1'b0;
            r_pf_tag    <= 16'd0;
            r_pf_data   <= 32'd0;
            r_is_pf     <= 1'b0;
`endif
        end else begin
`ifdef FETCH_PREFETCH_EN
            // Promote a prefetch hit into the main buffer; a demand fetch
            // completing on the same edge overrides this below.
            if (w_pf_hit) begin
                r_buf_valid <= 1'b1;
                r_buf_tag   <= r_pf_tag;
                r_buf_data  <= r_pf_data;
                r_pf_valid  <= 1'b0;
            end
`endif
            case (r_state)
                S_IDLE: begin
                    if (!instr_valid) begin
                        r_fetch_tag <= pc_addr;
                        r_mem_addr  <= {pc_addr[14:0], 1'b0};
                        r_mem_rd    <= 1'b1;
                        r_state     <= S_RD_LO;
`ifdef FETCH_PREFETCH_EN
                        r_is_pf     <= 1'b0;
                    end else if (!w_pf_have_next) begin
                        r_fetch_tag <= w_pc_next;
                        r_mem_addr  <= {w_pc_next[14:0], 1'b0};
                        r_mem_rd    <= 1'b1;
                        r_state     <= S_RD_LO;
                        r_is_pf     <= 1'b1;
`endif
                    end
                end
                S_RD_LO: begin
                    if (mem_ack) begin
                        r_lo       <= mem_data;
                        r_mem_addr <= {r_fetch_tag[14:0], 1'b1};
                        r_state    <= S_RD_HI;
                    end
                end
                S_RD_HI: begin
                    if (mem_ack) begin
                        r_mem_rd <= 1'b0;
                        r_state  <= S_IDLE;
`ifdef FETCH_PREFETCH_EN
                        if (r_is_pf) begin
                            r_pf_valid <= 1'b1;
                            r_pf_tag   <= r_fetch_tag;
                            r_pf_data  <= {mem_data, r_lo};
                        end else begin
                            r_buf_valid <= 1'b1;
                            r_buf_tag   <= r_fetch_tag;
                            r_buf_data  <= {mem_data, r_lo};
                        end
`else
                        // Written under fetch_tag even if the PC moved; IDLE
                        // then sees the mismatch and refetches.
                        r_buf_valid <= 1'b1;
                        r_buf_tag   <= r_fetch_tag;
                        r_buf_data  <= {mem_data, r_lo};
`endif
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_mem_rd <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
